// File: rtl/pool_pkg.sv
// Shared types and size helpers for the pooling engine.
package pool_pkg;

  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HANDOFF} pool_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pool_out(input int ifm, input int k, input int s);
    return (ifm - k) / s + 1;
  endfunction

  function automatic int pool_groups(input int depth, input int n);
    return (depth + n - 1) / n;
  endfunction

  function automatic int pool_sel_w(input int groups);
    return clog2_min1(groups);
  endfunction

endpackage

// File: rtl/pool_unit.sv
// One channel of the pooling datapath: running max or running sum over a window.
module pool_unit import pool_pkg::*; #(
  parameter int DW = 32,
  parameter int SH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          first,
  input  logic          last,
  input  pool_mode_e    mode,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int SW = DW + SH;

  logic signed [SW-1:0] din_x, acc_d, acc_q, avg;
  logic [DW-1:0]        dout_q;

  assign din_x = SW'($signed(din));

  // First element of a window seeds the accumulator in both modes.
  always_comb begin
    acc_d = acc_q;
    if (first)                 acc_d = din_x;
    else if (mode == POOL_AVG) acc_d = acc_q + din_x;
    else if (din_x > acc_q)    acc_d = din_x;
  end

  assign avg = acc_d >>> SH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      dout_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
      if (last) dout_q <= (mode == POOL_AVG) ? avg[DW-1:0] : acc_d[DW-1:0];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pool_engine_un.sv
// Pooling engine: walks group/oy/ox/ky/kx, one read per cycle, writes one result per window.
module pool_engine_un import pool_pkg::*; #(
  parameter  int DATA_WIDTH      = 32,
  parameter  int IFM_SIZE        = 10,
  parameter  int IFM_DEPTH       = 16,
  parameter  int KERNAL_SIZE     = 2,
  parameter  int STRIDE          = 2,
  parameter  int NUMBER_OF_UNITS = 3,
  localparam int OUT    = pool_out(IFM_SIZE, KERNAL_SIZE, STRIDE),
  localparam int GROUPS = pool_groups(IFM_DEPTH, NUMBER_OF_UNITS),
  localparam int SEL_W  = pool_sel_w(GROUPS),
  localparam int AR     = clog2_min1(IFM_SIZE * IFM_SIZE),
  localparam int AW     = clog2_min1(OUT * OUT)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_from_previous,
  input  logic                                  pool_mode,
  input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_in,
  output logic                                  ifm_enable_read_current,
  output logic [AR-1:0]                         ifm_address_read_current,
  output logic [SEL_W-1:0]                      ifm_sel_current,
  output logic                                  end_to_previous,
  input  logic                                  conv_ready,
  input  logic                                  end_from_next,
  output logic [NUMBER_OF_UNITS-1:0]            ifm_enable_write_next,
  output logic [AW-1:0]                         ifm_address_write_next,
  output logic [SEL_W-1:0]                      ifm_sel_next,
  output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_out,
  output logic                                  start_to_next,
  output logic                                  busy
);

  localparam int N  = NUMBER_OF_UNITS;
  localparam int DW = DATA_WIDTH;
  localparam int KW = clog2_min1(KERNAL_SIZE);
  localparam int OW = clog2_min1(OUT);

  pool_state_e state_q, state_d;
  pool_mode_e  mode_q;
  logic        pend_q, next_busy_q, end_q, go, handoff;

  logic [KW-1:0]    kx_q, kx_d, ky_q, ky_d;
  logic [OW-1:0]    ox_q, ox_d, oy_q, oy_d;
  logic [SEL_W-1:0] grp_q, grp_d;
  logic rd_en, kx_last, ky_last, ox_last, oy_last, grp_last, win_last, rd_final;

  // Stage 1 travels with the read; stage 2 is the visible write.
  logic             s1_vld_q, s1_first_q, s1_last_q, s1_final_q;
  logic [AW-1:0]    s1_waddr_q, waddr_q;
  logic [SEL_W-1:0] s1_grp_q, wsel_q;
  logic [N-1:0]     live, wen_q;
  logic             wfinal_q;
  logic [N-1:0][DW-1:0] unit_dout;

  assign rd_en    = (state_q == RUN);
  assign kx_last  = (kx_q == KW'(KERNAL_SIZE - 1));
  assign ky_last  = (ky_q == KW'(KERNAL_SIZE - 1));
  assign ox_last  = (ox_q == OW'(OUT - 1));
  assign oy_last  = (oy_q == OW'(OUT - 1));
  assign grp_last = (grp_q == SEL_W'(GROUPS - 1));
  assign win_last = kx_last && ky_last;
  assign rd_final = win_last && ox_last && oy_last && grp_last;

  always_comb begin
    kx_d  = kx_q;
    ky_d  = ky_q;
    ox_d  = ox_q;
    oy_d  = oy_q;
    grp_d = grp_q;
    if (rd_en) begin
      kx_d = kx_last ? '0 : kx_q + 1'b1;
      if (kx_last)                       ky_d  = ky_last  ? '0 : ky_q + 1'b1;
      if (win_last)                      ox_d  = ox_last  ? '0 : ox_q + 1'b1;
      if (win_last && ox_last)           oy_d  = oy_last  ? '0 : oy_q + 1'b1;
      if (win_last && ox_last && oy_last) grp_d = grp_last ? '0 : grp_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    handoff = 1'b0;
    case (state_q)
      IDLE:    if ((start_from_previous || pend_q) && !next_busy_q) begin
                 go      = 1'b1;
                 state_d = RUN;
               end
      RUN:     if (rd_final) state_d = DRAIN;
      DRAIN:   if (wfinal_q) state_d = HANDOFF;
      HANDOFF: if (conv_ready) begin
                 handoff = 1'b1;
                 state_d = IDLE;
               end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int u = 0; u < N; u++)
      live[u] = (int'(s1_grp_q) * N + u) < IFM_DEPTH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= POOL_MAX;
      pend_q      <= 1'b0;
      next_busy_q <= 1'b0;
      end_q       <= 1'b0;
      kx_q        <= '0;
      ky_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      grp_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_final_q  <= 1'b0;
      s1_waddr_q  <= '0;
      s1_grp_q    <= '0;
      wen_q       <= '0;
      waddr_q     <= '0;
      wsel_q      <= '0;
      wfinal_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= go ? 1'b0 : (pend_q | start_from_previous);
      // A handoff in the same cycle as end_from_next leaves the consumer busy.
      next_busy_q <= handoff ? 1'b1 : (end_from_next ? 1'b0 : next_busy_q);
      if (go) mode_q <= pool_mode_e'(pool_mode);
      end_q       <= rd_en && rd_final;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      grp_q       <= grp_d;
      s1_vld_q    <= rd_en;
      s1_first_q  <= (kx_q == '0) && (ky_q == '0);
      s1_last_q   <= win_last;
      s1_final_q  <= rd_final;
      s1_waddr_q  <= AW'(int'(oy_q) * OUT + int'(ox_q));
      s1_grp_q    <= grp_q;
      wen_q       <= (s1_vld_q && s1_last_q) ? live : '0;
      waddr_q     <= s1_waddr_q;
      wsel_q      <= s1_grp_q;
      wfinal_q    <= s1_vld_q && s1_final_q;
    end
  end

  for (genvar u = 0; u < N; u++) begin : g_unit
    pool_unit #(.DW(DW), .SH(2 * $clog2(KERNAL_SIZE))) u_unit (
      .clk  (clk),
      .rst_n(reset),
      .en   (s1_vld_q),
      .first(s1_first_q),
      .last (s1_last_q),
      .mode (mode_q),
      .din  (data_in[u*DW +: DW]),
      .dout (unit_dout[u])
    );
  end

  assign ifm_enable_read_current  = rd_en;
  assign ifm_address_read_current = AR'((int'(oy_q) * STRIDE + int'(ky_q)) * IFM_SIZE
                                        + int'(ox_q) * STRIDE + int'(kx_q));
  assign ifm_sel_current          = grp_q;
  assign end_to_previous          = end_q;
  assign ifm_enable_write_next    = wen_q;
  assign ifm_address_write_next   = waddr_q;
  assign ifm_sel_next             = wsel_q;
  assign data_out                 = unit_dout;
  assign start_to_next            = handoff;
  assign busy                     = (state_q != IDLE);

endmodule

// File: doc/pool_engine_un.md
POOL_ENGINE_UN -- requirements
Module: pool_engine_un

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, signed two's-complement element width; IFM_SIZE, 10, square input edge; IFM_DEPTH, 16, channel count; KERNAL_SIZE, 2, window edge, legal values 1/2/4; STRIDE, 2, window step; NUMBER_OF_UNITS, 3, parallel channels.
REQ-002 SHALL derive: OUT=(IFM_SIZE-KERNAL_SIZE)/STRIDE+1; GROUPS=ceil(IFM_DEPTH/NUMBER_OF_UNITS); SEL_W=max(1,clog2(GROUPS)); AR=clog2(IFM_SIZE^2); AW=clog2(OUT^2).
REQ-003 SHALL have ports: clk in 1 clock; reset in 1 asynchronous active-low reset.
REQ-004 SHALL have ports: start_from_previous in 1, frame-ready pulse; pool_mode in 1, 0=max, 1=average; data_in in N*DW, unit u at bits [u*DW +: DW].
REQ-005 SHALL have ports: ifm_enable_read_current out 1; ifm_address_read_current out AR; ifm_sel_current out SEL_W; end_to_previous out 1, pulse.
REQ-006 SHALL have ports: conv_ready in 1; end_from_next in 1, pulse; ifm_enable_write_next out N, per-unit; ifm_address_write_next out AW; ifm_sel_next out SEL_W; data_out out N*DW; start_to_next out 1, pulse; busy out 1.

Function
REQ-007 FSM states SHALL be IDLE, RUN, DRAIN, HANDOFF.
REQ-008 IDLE->RUN when start_from_previous (or latched pending start) is present and next_busy=0; pool_mode is sampled on this transition and held for the frame.
REQ-009 start_from_previous arriving outside IDLE or while next_busy=1 SHALL set start_pending; it is consumed on the next IDLE->RUN transition, and duplicate starts collapse.
REQ-010 In RUN one read SHALL be issued every cycle with no bubbles, order: group, oy, ox, ky, kx (kx fastest); address=(oy*STRIDE+ky)*IFM_SIZE+ox*STRIDE+kx; ifm_sel_current=group.
REQ-011 Read data SHALL be taken exactly one cycle after its address; the first read issues in the cycle after RUN is entered.
REQ-012 Max mode: signed compare, first window element initializes the accumulator.
REQ-013 Average mode: sum width DW+2*log2(KERNAL_SIZE); result=sum arithmetic-shift-right 2*log2(KERNAL_SIZE) (floor), truncated to DW.
REQ-014 Window result SHALL be written two cycles after its last read address, with ifm_address_write_next=oy*OUT+ox and ifm_sel_next=group.
REQ-015 ifm_enable_write_next bit u SHALL be 1 only if group*N+u < IFM_DEPTH.
REQ-016 After the final read, RUN->DRAIN and end_to_previous SHALL pulse for one cycle, in the cycle after the final read.
REQ-017 DRAIN->HANDOFF after the final write.
REQ-018 In HANDOFF, start_to_next SHALL pulse for one cycle at the first cycle with conv_ready=1, setting next_busy, then go to IDLE; it holds while conv_ready=0.
REQ-019 end_from_next SHALL clear next_busy; if it coincides with start_to_next, next_busy ends at 1.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Read-address, sel and counter values SHALL wrap to 0 after the last group and hold 0 in IDLE.

Reset
REQ-022 Asserting reset, including mid-frame, SHALL force IDLE and clear start_pending, next_busy, counters and accumulators.
REQ-023 While reset is asserted, every output SHALL be 0.
REQ-024 The first operation after reset release SHALL require a new start_from_previous.

Structure
REQ-025 Package pool_pkg SHALL hold the pool_mode encoding, the FSM state type and functions for OUT, GROUPS and SEL_W.
REQ-026 Sub-module pool_unit SHALL be a per-channel max/sum accumulator instantiated NUMBER_OF_UNITS times; the FSM and address generation SHALL be in the top.

Verification (IFM_SIZE=4, K=2, S=2, N=3, DEPTH=4 => OUT=2, GROUPS=2, 32 reads)
REQ-027 Max, data=address, all units: window(0,0) reads 0,1,4,5 -> 5; window(1,1) -> 15; 32 consecutive read cycles.
REQ-028 Average, window values -1,-2,-3,-4 -> -3; window 0,1,4,5 -> 2.
REQ-029 Group 1 writes -> ifm_enable_write_next=3'b001 and ifm_sel_next=1; group 0 writes -> 3'b111.
REQ-030 start during next_busy=1 -> no read until end_from_next; first read in the cycle after IDLE->RUN.
REQ-031 conv_ready=0 at frame end for 5 cycles -> start_to_next delayed 5 cycles, one-cycle pulse.
REQ-032 reset asserted at read 10 -> all outputs 0; after release no reads until new start; next frame gives correct results.
